// File: rtl/hamming_encoder.sv
// hamming_encoder
//   Two-stage pipelined extended Hamming (32,26) SECDED encoder with
//   single-bit error injection for exercising a downstream decoder.
//
//   Ports:
//     clk        rising-edge clock for all state
//     rst_n      asynchronous active-low reset
//     data_in    26-bit payload word
//     in_valid   data_in is valid
//     in_ready   encoder can accept a word this cycle
//     data_out   32-bit codeword (bit i = Hamming position i, bit 0 = overall parity)
//     out_valid  data_out is valid
//     out_ready  downstream accepts data_out this cycle
//     inj_req    one-cycle pulse arming single-bit error injection
//     inj_pos    codeword bit index to flip, sampled with inj_req
//     inj_armed  injection armed and not yet applied
//     word_cnt   count of completed output handshakes (wraps)
module hamming_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [25:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        inj_req,
  input  logic [4:0]  inj_pos,
  output logic        inj_armed,
  output logic [15:0] word_cnt
);

  logic        s1_valid;
  logic [25:0] s1_data;
  logic [4:0]  inj_pos_q;
  logic        s2_load;
  logic        s1_load;
  logic        apply_inj;
  logic [31:0] codeword;
  logic [31:0] cw_final;

  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [31:0] cw;
    logic [4:0]  ppos;
    logic        p;
    int unsigned j;
    cw = '0;
    j  = 0;
    // Data fills every non-power-of-two position in ascending order.
    for (int unsigned i = 1; i < 32; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i[4:0]] = d[j[4:0]];
        j++;
      end
    end
    // Parity positions are still zero here and no group covers another
    // parity position, so they can be filled in any order.
    for (int unsigned k = 0; k < 5; k++) begin
      p = 1'b0;
      for (int unsigned i = 1; i < 32; i++) begin
        if (((i >> k) & 1) != 0) p = p ^ cw[i[4:0]];
      end
      ppos       = 5'(32'd1 << k);
      cw[ppos]   = p;
    end
    cw[0] = ^cw[31:1];
    return cw;
  endfunction

  always_comb begin
    s2_load  = !out_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_ready = rst_n && s1_load;
    // An inj_req coinciding with the load defers injection to the next word.
    apply_inj = inj_armed && s1_valid && s2_load && !inj_req;
    codeword  = encode(s1_data);
    cw_final  = codeword ^ (apply_inj ? (32'd1 << inj_pos_q) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      inj_armed <= 1'b0;
      inj_pos_q <= '0;
      word_cnt  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1_data <= data_in;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) data_out <= cw_final;
      end
      if (inj_req) begin
        inj_armed <= 1'b1;
        inj_pos_q <= inj_pos;
      end else if (apply_inj) begin
        inj_armed <= 1'b0;
      end
      if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hamming_encoder.sv
module tb_hamming_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        inj_req;
  logic [4:0]  inj_pos;
  logic        inj_armed;
  logic [15:0] word_cnt;

  hamming_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inj_req   (inj_req),
    .inj_pos   (inj_pos),
    .inj_armed (inj_armed),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] data;
    bit          has_exp;
    logic [31:0] exp_cw;
    int          inj;
  } sb_t;

  sb_t sbq[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] syndrome(input logic [31:0] cw);
    logic [4:0] s = '0;
    for (int unsigned i = 1; i < 32; i++)
      if (cw[i[4:0]]) s = s ^ i[4:0];
    return s;
  endfunction

  function automatic logic [25:0] extract(input logic [31:0] cw);
    logic [25:0] d = '0;
    int unsigned j = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j[4:0]] = cw[i[4:0]];
        j++;
      end
    end
    return d;
  endfunction

  // Monitor: one pop per output handshake, with an independent decoder check.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h expected none", data_out);
      end else begin
        sb_t         e;
        logic [31:0] fix;
        e   = sbq.pop_front();
        fix = data_out;
        if (e.has_exp) check("codeword", data_out, e.exp_cw);
        if (e.inj >= 0) begin
          check("dec_syndrome", 32'(syndrome(data_out)), 32'(e.inj));
          check("dec_parity_odd", 32'(^data_out), 32'd1);
          fix[e.inj] = ~fix[e.inj];
        end else begin
          check("dec_syndrome", 32'(syndrome(data_out)), 32'd0);
          check("dec_parity_even", 32'(^data_out), 32'd0);
        end
        check("dec_payload", 32'(extract(fix)), 32'(e.data));
      end
    end
  end

  task automatic send(input logic [25:0] d, input bit he, input logic [31:0] ex, input int inj);
    sb_t e;
    int  n = 0;
    data_in  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      e.data    = d;
      e.has_exp = he;
      e.exp_cw  = ex;
      e.inj     = inj;
      if (inj >= 0) e.exp_cw = ex ^ (32'd1 << inj);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic arm(input logic [4:0] pos);
    inj_pos = pos;
    inj_req = 1'b1;
    @(posedge clk);
    #1 inj_req = 1'b0;
  endtask

  logic [25:0] vec_d [7] = '{26'h3FFFFFF, 26'h0000001, 26'h2000000, 26'h0000002,
                              26'h0000004, 26'h0000008, 26'h0000010};
  logic [31:0] vec_c [7] = '{32'hFFFFFFFF, 32'h0000000F, 32'h80010116, 32'h00000033,
                              32'h00000055, 32'h00000096, 32'h00000303};

  initial begin
    rst_n     = 1'b0;
    data_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    inj_req   = 1'b0;
    inj_pos   = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_inj_armed", 32'(inj_armed), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);

    // Latency: accepted at edge N, valid after N+1.
    send(26'h0, 1'b1, 32'h0, -1);
    @(negedge clk);
    check("latency_n", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("latency_n1", 32'(out_valid), 32'd1);
    drain();

    foreach (vec_d[i]) send(vec_d[i], 1'b1, vec_c[i], -1);
    drain();

    // Basic injection: one corrupted word, then clean.
    arm(5'd5);
    check("armed_set", 32'(inj_armed), 32'd1);
    send(26'h0, 1'b1, 32'h0, 5);
    drain();
    check("armed_clr", 32'(inj_armed), 32'd0);
    send(26'h0, 1'b1, 32'h0, -1);
    drain();

    // Re-arm while armed overwrites the position.
    arm(5'd3);
    arm(5'd9);
    send(26'h0, 1'b1, 32'h0, 9);
    drain();

    // inj_req coinciding with an s2 load leaves that word clean.
    send(26'h1, 1'b1, 32'h0000000F, -1);
    inj_pos = 5'd7;
    inj_req = 1'b1;
    @(posedge clk);
    #1 inj_req = 1'b0;
    check("coincide_armed", 32'(inj_armed), 32'd1);
    send(26'h1, 1'b1, 32'h0000000F, 7);
    drain();
    check("coincide_clr", 32'(inj_armed), 32'd0);

    // Backpressure: two buffered, in_ready low, data_out held.
    pulse_reset();
    out_ready = 1'b0;
    send(26'h3FFFFFF, 1'b1, 32'hFFFFFFFF, -1);
    send(26'h0000001, 1'b1, 32'h0000000F, -1);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_data_out", data_out, 32'hFFFFFFFF);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(26'h0000002, 1'b1, 32'h00000033, -1);
    send(26'h0000004, 1'b1, 32'h00000055, -1);
    drain();
    check("bp_word_cnt", 32'(word_cnt), 32'd4);

    // Asynchronous reset with words in flight and injection armed.
    out_ready = 1'b0;
    send(26'h0000008, 1'b0, 32'h0, -1);
    send(26'h0000010, 1'b0, 32'h0, -1);
    arm(5'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_inj_armed", 32'(inj_armed), 32'd0);
    check("async_word_cnt", 32'(word_cnt), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    sbq.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end

    // Random payloads through the reference decoder, some injected.
    for (int i = 0; i < 24; i++) begin
      logic [25:0] d;
      d = 26'($urandom);
      if (i % 3 == 0) begin
        logic [4:0] p;
        p = 5'($urandom_range(0, 31));
        arm(p);
        send(d, 1'b0, 32'h0, int'(p));
      end else begin
        send(d, 1'b0, 32'h0, -1);
      end
    end
    drain();

    // word_cnt wrap.
    pulse_reset();
    for (int i = 0; i < 65535; i++) send(26'(i), 1'b0, 32'h0, -1);
    drain();
    check("cnt_ffff", 32'(word_cnt), 32'h0000FFFF);
    send(26'h0, 1'b1, 32'h0, -1);
    drain();
    check("cnt_wrap", 32'(word_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
